// File: rtl/evg_tx_pkg.sv
// Shared constants and the TX word builder for the EVG event scheduler.
`default_nettype none

package evg_tx_pkg;

  localparam logic [7:0] K28_5      = 8'hBC;
  localparam logic [7:0] NULL_EVENT = 8'h00;

  localparam logic [1:0] CHARISK_COMMA = 2'b10;
  localparam logic [1:0] CHARISK_DATA  = 2'b00;

  // High byte carries the event code or the comma; low byte is always the distributed bus.
  function automatic logic [15:0] tx_word(input logic [7:0] code,
                                          input logic [7:0] dbus,
                                          input logic       isComma);
    return {(isComma ? K28_5 : code), dbus};
  endfunction

endpackage

`default_nettype wire

// File: rtl/evg_tx_priority_pick.sv
// Combinational fixed-priority picker: isolates the lowest-index set request bit.
`default_nettype none

module evg_tx_priority_pick #(
  parameter int REQUESTER_COUNT = 4
) (
  input  logic [REQUESTER_COUNT-1:0] req_i,
  output logic [REQUESTER_COUNT-1:0] onehot_o,
  output logic                       valid_o
);

  // Two's-complement trick: req & -req keeps only the lowest set bit.
  assign onehot_o = req_i & (~req_i + REQUESTER_COUNT'(1));
  assign valid_o  = |req_i;

endmodule

`default_nettype wire

// File: rtl/evg_tx_event_scheduler.sv
// Arbitrates N event requesters onto the EVG TX event byte, inserting periodic
// K28.5 commas and null events on idle slots.
`default_nettype none

module evg_tx_event_scheduler
  import evg_tx_pkg::*;
#(
  parameter int REQUESTER_COUNT       = 4,
  parameter int DISTRIBUTED_BUS_WIDTH = 8,
  parameter int COMMA_INTERVAL        = 64
) (
  input  logic                             evgTxClk,
  input  logic                             evgTxReset,
  input  logic [REQUESTER_COUNT-1:0]       evgReqStrobe,
  input  logic [8*REQUESTER_COUNT-1:0]     evgReqCode,
  input  logic [DISTRIBUTED_BUS_WIDTH-1:0] evgDistributedBus,
  input  logic                             evgOverflowClear,
  output logic [15:0]                      evgTxData,
  output logic [1:0]                       evgTxCharIsK,
  output logic [REQUESTER_COUNT-1:0]       evgGrant,
  output logic [REQUESTER_COUNT-1:0]       evgPending,
  output logic [REQUESTER_COUNT-1:0]       evgOverflow
);

  localparam logic [15:0] COMMA_LAST = 16'(COMMA_INTERVAL - 1);

  logic [15:0]                       cnt_q, cnt_d;
  logic [REQUESTER_COUNT-1:0]        pending_q, pending_d;
  logic [REQUESTER_COUNT-1:0][7:0]   code_q, code_d;
  logic [REQUESTER_COUNT-1:0]        ovf_q, ovf_d;
  logic [15:0]                       txData_q, txData_d;
  logic [1:0]                        charIsK_q, charIsK_d;
  logic [REQUESTER_COUNT-1:0]        grant_q, grant_d;

  logic                              comma_now;
  logic [REQUESTER_COUNT-1:0]        pick_onehot;
  logic                              pick_valid;
  logic [REQUESTER_COUNT-1:0]        win;
  logic [REQUESTER_COUNT-1:0]        ovf_set;
  logic [7:0]                        sel_code;
  logic [7:0]                        dbus_ext;

  if (DISTRIBUTED_BUS_WIDTH >= 8) begin : g_dbus_trunc
    assign dbus_ext = evgDistributedBus[7:0];
  end else begin : g_dbus_pad
    assign dbus_ext = {{(8-DISTRIBUTED_BUS_WIDTH){1'b0}}, evgDistributedBus};
  end

  evg_tx_priority_pick #(
    .REQUESTER_COUNT(REQUESTER_COUNT)
  ) u_pick (
    .req_i    (pending_q),
    .onehot_o (pick_onehot),
    .valid_o  (pick_valid)
  );

  assign comma_now = (cnt_q == COMMA_LAST);
  assign cnt_d     = comma_now ? 16'd0 : cnt_q + 16'd1;

  // A comma slot steals the word outright: nobody wins, pending codes wait.
  assign win = comma_now ? '0 : pick_onehot;

  always_comb begin
    sel_code = NULL_EVENT;
    for (int i = 0; i < REQUESTER_COUNT; i++) begin
      if (win[i]) sel_code = code_q[i];
    end
  end

  // A strobe coinciding with its own win refills the slot rather than overflowing.
  always_comb begin
    pending_d = pending_q;
    code_d    = code_q;
    ovf_set   = '0;
    for (int i = 0; i < REQUESTER_COUNT; i++) begin
      if (win[i]) pending_d[i] = 1'b0;
      if (evgReqStrobe[i] && (evgReqCode[8*i +: 8] != NULL_EVENT)) begin
        if (!pending_q[i] || win[i]) begin
          pending_d[i] = 1'b1;
          code_d[i]    = evgReqCode[8*i +: 8];
        end else begin
          ovf_set[i] = 1'b1;
        end
      end
    end
  end

  assign ovf_d = (evgOverflowClear ? '0 : ovf_q) | ovf_set;

  always_comb begin
    txData_d  = tx_word(pick_valid ? sel_code : NULL_EVENT, dbus_ext, comma_now);
    charIsK_d = comma_now ? CHARISK_COMMA : CHARISK_DATA;
    grant_d   = win;
  end

  always_ff @(posedge evgTxClk or posedge evgTxReset) begin
    if (evgTxReset) begin
      cnt_q     <= '0;
      pending_q <= '0;
      code_q    <= '0;
      ovf_q     <= '0;
      txData_q  <= tx_word(NULL_EVENT, 8'h00, 1'b1);
      charIsK_q <= CHARISK_COMMA;
      grant_q   <= '0;
    end else begin
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      code_q    <= code_d;
      ovf_q     <= ovf_d;
      txData_q  <= txData_d;
      charIsK_q <= charIsK_d;
      grant_q   <= grant_d;
    end
  end

  assign evgTxData    = txData_q;
  assign evgTxCharIsK = charIsK_q;
  assign evgGrant     = grant_q;
  assign evgPending   = pending_q;
  assign evgOverflow  = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_evg_tx_event_scheduler.sv
// Directed self-checking bench for evg_tx_event_scheduler (N=4, comma every 64 words).
`default_nettype none

module tb_evg_tx_event_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  strobe = '0;
  logic [31:0] code = '0;
  logic [7:0]  dbus = 8'h05;
  logic        ovf_clr = 1'b0;
  logic [15:0] tx_data;
  logic [1:0]  tx_k;
  logic [3:0]  grant, pending, overflow;

  int vectors = 0;
  int miscompares = 0;
  int edges = 0;

  evg_tx_event_scheduler dut (
    .evgTxClk          (clk),
    .evgTxReset        (rst),
    .evgReqStrobe      (strobe),
    .evgReqCode        (code),
    .evgDistributedBus (dbus),
    .evgOverflowClear  (ovf_clr),
    .evgTxData         (tx_data),
    .evgTxCharIsK      (tx_k),
    .evgGrant          (grant),
    .evgPending        (pending),
    .evgOverflow       (overflow)
  );

  always #5 clk = ~clk;

  // Edges since reset release; the word produced by edge e is a comma when e % 64 == 0.
  always @(posedge clk or posedge rst) begin
    if (rst) edges <= 0;
    else     edges <= edges + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until the next n edges contain no comma.
  task automatic avoid_comma(input int n);
    while ((edges % 64) + n >= 64) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    vectors++; if ({tx_k, tx_data} !== 18'h2BC00) begin miscompares++; $display("FAIL reset_word: got %h required %h", {tx_k, tx_data}, 18'h2BC00); end
    vectors++; if (grant !== 4'b0) begin miscompares++; $display("FAIL reset_grant: got %b required 0000", grant); end
    vectors++; if (pending !== 4'b0) begin miscompares++; $display("FAIL reset_pending: got %b required 0000", pending); end
    vectors++; if (overflow !== 4'b0) begin miscompares++; $display("FAIL reset_overflow: got %b required 0000", overflow); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_idle_commas();
    logic [17:0] exp;
    for (int c = 0; c < 200; c++) begin
      tick();
      exp = ((edges % 64) == 0) ? 18'h2BC05 : 18'h00005;
      vectors++; if ({tx_k, tx_data} !== exp) begin miscompares++; $display("FAIL idle_word edge %0d: got %h required %h", edges, {tx_k, tx_data}, exp); end
      vectors++; if (grant !== 4'b0) begin miscompares++; $display("FAIL idle_grant edge %0d: got %b required 0000", edges, grant); end
    end
  endtask

  task automatic test_two_requesters();
    avoid_comma(4);
    strobe = 4'b1010; code = 32'h70_00_7A_00;
    tick(); strobe = '0; code = '0;
    vectors++; if (pending !== 4'b1010) begin miscompares++; $display("FAIL two_pending: got %b required 1010", pending); end
    vectors++; if ({grant, tx_data} !== {4'b0000, 16'h0005}) begin miscompares++; $display("FAIL two_latency: got %h required %h", {grant, tx_data}, {4'b0000, 16'h0005}); end
    tick();
    vectors++; if ({tx_k, grant, tx_data} !== {2'b00, 4'b0010, 16'h7A05}) begin miscompares++; $display("FAIL two_first: got %h required %h", {tx_k, grant, tx_data}, {2'b00, 4'b0010, 16'h7A05}); end
    tick();
    vectors++; if ({tx_k, grant, tx_data} !== {2'b00, 4'b1000, 16'h7005}) begin miscompares++; $display("FAIL two_second: got %h required %h", {tx_k, grant, tx_data}, {2'b00, 4'b1000, 16'h7005}); end
    tick();
    vectors++; if ({grant, pending, tx_data} !== {4'b0, 4'b0, 16'h0005}) begin miscompares++; $display("FAIL two_drain: got %h required %h", {grant, pending, tx_data}, {4'b0, 4'b0, 16'h0005}); end
  endtask

  task automatic test_comma_preempt();
    int guard = 0;
    while ((edges % 64) != 62 && guard < 70) begin tick(); guard++; end
    strobe = 4'b0001; code = 32'h0000_007D;
    tick(); strobe = '0; code = '0;
    vectors++; if (pending !== 4'b0001) begin miscompares++; $display("FAIL pre_pending: got %b required 0001", pending); end
    tick();
    vectors++; if ({tx_k, grant, tx_data} !== {2'b10, 4'b0000, 16'hBC05}) begin miscompares++; $display("FAIL pre_comma: got %h required %h", {tx_k, grant, tx_data}, {2'b10, 4'b0000, 16'hBC05}); end
    vectors++; if (pending !== 4'b0001) begin miscompares++; $display("FAIL pre_wait: got %b required 0001", pending); end
    tick();
    vectors++; if ({tx_k, grant, tx_data} !== {2'b00, 4'b0001, 16'h7D05}) begin miscompares++; $display("FAIL pre_event: got %h required %h", {tx_k, grant, tx_data}, {2'b00, 4'b0001, 16'h7D05}); end
  endtask

  task automatic test_overflow();
    avoid_comma(5);
    strobe = 4'b0101; code = 32'h00_11_00_40;
    tick();
    strobe = 4'b0100; code = 32'h00_22_00_00;
    vectors++; if ({pending, overflow} !== 8'b0101_0000) begin miscompares++; $display("FAIL ovf_setup: got %b required 01010000", {pending, overflow}); end
    tick(); strobe = '0; code = '0;
    vectors++; if ({grant, tx_data} !== {4'b0001, 16'h4005}) begin miscompares++; $display("FAIL ovf_req0: got %h required %h", {grant, tx_data}, {4'b0001, 16'h4005}); end
    vectors++; if (overflow !== 4'b0100) begin miscompares++; $display("FAIL ovf_flag: got %b required 0100", overflow); end
    tick();
    vectors++; if ({grant, tx_data} !== {4'b0100, 16'h1105}) begin miscompares++; $display("FAIL ovf_kept: got %h required %h", {grant, tx_data}, {4'b0100, 16'h1105}); end
    tick();
    vectors++; if ({grant, tx_data, overflow} !== {4'b0000, 16'h0005, 4'b0100}) begin miscompares++; $display("FAIL ovf_dropped: got %h required %h", {grant, tx_data, overflow}, {4'b0000, 16'h0005, 4'b0100}); end
    ovf_clr = 1'b1;
    tick(); ovf_clr = 1'b0;
    vectors++; if (overflow !== 4'b0000) begin miscompares++; $display("FAIL ovf_clear: got %b required 0000", overflow); end
    // Clear and a fresh overflow on requester 3 in the same cycle: set must win.
    avoid_comma(5);
    strobe = 4'b1001; code = 32'h33_00_00_41;
    tick();
    strobe = 4'b1000; code = 32'h34_00_00_00; ovf_clr = 1'b1;
    tick(); strobe = '0; code = '0; ovf_clr = 1'b0;
    vectors++; if (overflow !== 4'b1000) begin miscompares++; $display("FAIL ovf_set_wins: got %b required 1000", overflow); end
    tick();
    vectors++; if ({grant, tx_data} !== {4'b1000, 16'h3305}) begin miscompares++; $display("FAIL ovf_req3: got %h required %h", {grant, tx_data}, {4'b1000, 16'h3305}); end
    ovf_clr = 1'b1;
    tick(); ovf_clr = 1'b0;
  endtask

  task automatic test_back_to_back();
    avoid_comma(6);
    strobe = 4'b0010; code = 32'h0000_6100;
    tick();
    code = 32'h0000_6200;
    tick();
    vectors++; if ({grant, tx_data} !== {4'b0010, 16'h6105}) begin miscompares++; $display("FAIL b2b_first: got %h required %h", {grant, tx_data}, {4'b0010, 16'h6105}); end
    vectors++; if ({pending, overflow} !== 8'b0010_0000) begin miscompares++; $display("FAIL b2b_refill: got %b required 00100000", {pending, overflow}); end
    code = 32'h0000_6300;
    tick(); strobe = '0; code = '0;
    vectors++; if ({grant, tx_data} !== {4'b0010, 16'h6205}) begin miscompares++; $display("FAIL b2b_second: got %h required %h", {grant, tx_data}, {4'b0010, 16'h6205}); end
    tick();
    vectors++; if ({grant, tx_data, overflow} !== {4'b0010, 16'h6305, 4'b0000}) begin miscompares++; $display("FAIL b2b_third: got %h required %h", {grant, tx_data, overflow}, {4'b0010, 16'h6305, 4'b0000}); end
    tick();
    vectors++; if ({grant, pending} !== 8'h00) begin miscompares++; $display("FAIL b2b_drain: got %h required 00", {grant, pending}); end
  endtask

  task automatic test_null_and_reset();
    logic [17:0] exp;
    avoid_comma(3);
    strobe = 4'b0100; code = 32'h0000_0000;
    tick(); strobe = '0;
    vectors++; if ({pending, overflow} !== 8'h00) begin miscompares++; $display("FAIL null_pending: got %h required 00", {pending, overflow}); end
    tick();
    vectors++; if ({grant, tx_data} !== {4'b0000, 16'h0005}) begin miscompares++; $display("FAIL null_grant: got %h required %h", {grant, tx_data}, {4'b0000, 16'h0005}); end
    // Park three codes behind a comma-free window, then reset mid-cycle.
    dbus = 8'hA3;
    strobe = 4'b0111; code = 32'h00_73_72_71;
    tick(); strobe = '0; code = '0;
    vectors++; if (pending !== 4'b0111) begin miscompares++; $display("FAIL rst_setup: got %b required 0111", pending); end
    vectors++; if (tx_data[7:0] !== 8'hA3) begin miscompares++; $display("FAIL dbus_latency: got %h required a3", tx_data[7:0]); end
    #2 rst = 1'b1;
    #1;
    vectors++; if ({tx_k, tx_data} !== 18'h2BC00) begin miscompares++; $display("FAIL rst_async_word: got %h required %h", {tx_k, tx_data}, 18'h2BC00); end
    vectors++; if ({grant, pending} !== 8'h00) begin miscompares++; $display("FAIL rst_async_state: got %h required 00", {grant, pending}); end
    tick(); tick();
    @(negedge clk);
    rst = 1'b0;
    dbus = 8'h05;
    for (int c = 0; c < 70; c++) begin
      tick();
      exp = ((edges % 64) == 0) ? 18'h2BC05 : 18'h00005;
      vectors++; if ({grant, tx_k, tx_data} !== {4'b0000, exp}) begin miscompares++; $display("FAIL rst_discard edge %0d: got %h required %h", edges, {grant, tx_k, tx_data}, {4'b0000, exp}); end
    end
  endtask

  initial begin
    test_reset();
    test_idle_commas();
    test_two_requesters();
    test_comma_preempt();
    test_overflow();
    test_back_to_back();
    test_null_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
